scoreboard_display: RTL



---
 rtl/scoreboard_display_if.sv | 28 ++
 rtl/scoreboard_display.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/scoreboard_display_if.sv
// ---------------------------------------------------------------------------
// scoreboard_display_if
// Time-multiplexed status bus from the game top. The game top presents one
// player's slot at a time.
//   bus_player   [1:0] : player index (output_player of the game top)
//   bus_position [2:0] : position of that player
//   bus_status   [3:0] : status_code of that player
// Modports:
//   master : game top side, drives the bus
//   slave  : scoreboard side, samples the bus
// ---------------------------------------------------------------------------
interface scoreboard_display_if;
  logic [1:0] bus_player;
  logic [2:0] bus_position;
  logic [3:0] bus_status;

  modport master (
    output bus_player,
    output bus_position,
    output bus_status
  );

  modport slave (
    input bus_player,
    input bus_position,
    input bus_status
  );
endinterface

// File: rtl/scoreboard_display.sv
// ---------------------------------------------------------------------------
// scoreboard_display
// Receives the time-multiplexed player status bus and debounces each sample.
// It keeps one slot (position, status) per player and flags newly detected
// wins. It drives a scanned 4-digit common-anode seven-segment display,
// showing one digit per player, plus per-player win LEDs.
//
// Parameters:
//   SCAN_DIV    : clock cycles each digit stays enabled (>= 2)
//   STABLE      : identical consecutive samples needed to commit (1..15)
//   BLINK_SCANS : full scan rounds per blink half-period (>= 1)
//
// Ports:
//   clk        : system clock
//   rst        : synchronous reset, active low
//   bus        : status bus (slave modport)
//   seg  [6:0] : segments {g,f,e,d,c,b,a}, active low
//   dp         : decimal point, active low, marks the last reported player
//   an   [3:0] : digit enables, active low, an[i] selects player i
//   led  [3:0] : led[i] high while player i is in win state
//   win_pulse  : one-cycle strobe on a newly detected win
//   win_player : player index of the most recent win_pulse
// ---------------------------------------------------------------------------
module scoreboard_display #(
  parameter int SCAN_DIV    = 2500,
  parameter int STABLE      = 2,
  parameter int BLINK_SCANS = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  scoreboard_display_if.slave  bus,
  output logic [6:0]           seg,
  output logic                 dp,
  output logic [3:0]           an,
  output logic [3:0]           led,
  output logic                 win_pulse,
  output logic [1:0]           win_player
);

  localparam int SCAN_W = $clog2(SCAN_DIV);
  // The filter count must be able to hold STABLE itself.
  localparam int CNT_W  = $clog2(STABLE + 1);
  localparam int BLK_W  = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;

  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_SAT   = CNT_W'(STABLE);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [BLK_W-1:0]  BLK_LAST  = BLK_W'(BLINK_SCANS - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_F     = 7'b0001110;

  // Slot classification and glyph lookup.
  function automatic logic is_fault(input logic [3:0] st);
    return (st == 4'b1000);
  endfunction

  function automatic logic is_win(input logic [3:0] st);
    return st[2] && (st != 4'b1000);
  endfunction

  function automatic logic [6:0] glyph(input logic [2:0] pos);
    logic [6:0] g;
    case (pos)
      3'd0:    g = 7'b1000000;
      3'd1:    g = 7'b1111001;
      3'd2:    g = 7'b0100100;
      3'd3:    g = 7'b0110000;
      3'd4:    g = 7'b0011001;
      3'd5:    g = 7'b0010010;
      3'd6:    g = 7'b0000010;
      3'd7:    g = 7'b1111000;
      default: g = 7'b1111111;
    endcase
    return g;
  endfunction

  // ------------------------------------------------------------------ state
  logic [8:0]            sample_r;
  logic [CNT_W-1:0]      cnt_r;
  logic [3:0][2:0]       pos_r;
  logic [3:0][3:0]       st_r;
  logic [1:0]            last_player_r;

  logic [SCAN_W-1:0]     scan_cnt_r;
  logic [1:0]            digit_r;
  logic [BLK_W-1:0]      blink_cnt_r;
  logic                  blink_on_r;

  // ------------------------------------------------------------ comb nets
  logic [8:0]            sample_s;
  logic                  same_s;
  logic [CNT_W-1:0]      cnt_next_s;
  logic                  commit_s;
  logic                  now_win_s;
  logic                  was_win_s;
  logic                  new_win_s;
  logic                  scan_wrap_s;
  logic                  round_done_s;
  logic [2:0]            pos_cur_s;
  logic [3:0]            st_cur_s;
  logic [6:0]            seg_next_s;
  logic                  dp_next_s;
  logic [3:0]            an_next_s;

  assign sample_s = {bus.bus_player, bus.bus_position, bus.bus_status};
  assign same_s   = (sample_s == sample_r);

  // Filter counter: saturating run-length of identical samples and commit strobe.
  always_comb begin
    cnt_next_s = CNT_ONE;
    if (same_s) begin
      if (cnt_r == CNT_SAT) begin
        cnt_next_s = cnt_r;
      end else begin
        cnt_next_s = cnt_r + CNT_ONE;
      end
    end else begin
      cnt_next_s = CNT_ONE;
    end
    // Commit only on the cycle the run reaches STABLE, not while it stays
    // saturated. A new run always commits when STABLE is 1.
    commit_s = (cnt_next_s == CNT_SAT) && (!same_s || (cnt_r != CNT_SAT));
  end

  // A win is new only if the target slot was not already in win state.
  assign now_win_s = is_win(bus.bus_status);
  assign was_win_s = is_win(st_r[bus.bus_player]);
  assign new_win_s = commit_s && now_win_s && !was_win_s;

  // Input filter, slot storage, win detection and LEDs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sample_r      <= 9'd0;
      cnt_r         <= '0;
      pos_r         <= '0;
      st_r          <= '0;
      last_player_r <= 2'd0;
      led           <= 4'd0;
      win_pulse     <= 1'b0;
      win_player    <= 2'd0;
    end else begin
      sample_r  <= sample_s;
      cnt_r     <= cnt_next_s;
      win_pulse <= new_win_s;
      if (commit_s) begin
        pos_r[bus.bus_player] <= bus.bus_position;
        st_r[bus.bus_player]  <= bus.bus_status;
        led[bus.bus_player]   <= now_win_s;
        last_player_r         <= bus.bus_player;
      end
      if (new_win_s) begin
        win_player <= bus.bus_player;
      end
    end
  end

  assign scan_wrap_s  = (scan_cnt_r == SCAN_LAST);
  assign round_done_s = scan_wrap_s && (digit_r == 2'd3);

  // Digit scan and blink phase; blink rounds are counted on digit 3->0 wraps.
  always_ff @(posedge clk) begin
    if (!rst) begin
      scan_cnt_r  <= '0;
      digit_r     <= 2'd0;
      blink_cnt_r <= '0;
      blink_on_r  <= 1'b1;
    end else begin
      if (scan_wrap_s) begin
        scan_cnt_r <= '0;
        digit_r    <= digit_r + 2'd1;
      end else begin
        scan_cnt_r <= scan_cnt_r + SCAN_W'(1);
      end
      if (round_done_s) begin
        if (blink_cnt_r == BLK_LAST) begin
          blink_cnt_r <= '0;
          blink_on_r  <= ~blink_on_r;
        end else begin
          blink_cnt_r <= blink_cnt_r + BLK_W'(1);
        end
      end
    end
  end

  // Content of the digit currently selected by the scan.
  always_comb begin
    pos_cur_s  = pos_r[digit_r];
    st_cur_s   = st_r[digit_r];
    seg_next_s = glyph(pos_cur_s);
    if (is_fault(st_cur_s)) begin
      seg_next_s = SEG_F;
    end else if (is_win(st_cur_s) && !blink_on_r) begin
      seg_next_s = SEG_BLANK;
    end else begin
      seg_next_s = glyph(pos_cur_s);
    end
    an_next_s = ~(4'b0001 << digit_r);
    dp_next_s = (digit_r == last_player_r) ? 1'b0 : 1'b1;
  end

  // seg/dp/an share one register stage so they switch on the same edge and
  // the segments never show a neighbour's content while the anode moves.
  always_ff @(posedge clk) begin
    if (!rst) begin
      seg <= SEG_BLANK;
      dp  <= 1'b1;
      an  <= 4'b1111;
    end else begin
      seg <= seg_next_s;
      dp  <= dp_next_s;
      an  <= an_next_s;
    end
  end

endmodule
